// File: rtl/copro_bus_ctrl.sv
// Bus controller for the OPC co-processor: tube/IRAM/external-SRAM decode,
// two-byte external SRAM sequencing with wait states, and interrupt merging.
module copro_bus_ctrl #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-4:0] TUBE_BASE   = 13'h1FDF,
  parameter int                IRAM_AW     = 13,
  parameter int                XRAM_AW     = 19,
  parameter int                WAIT_STATES = 1,
  parameter int                NIRQ        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [15:0]        cpu_dout,
  input  logic               cpu_rnw,
  input  logic               cpu_vpa,
  output logic [15:0]        cpu_din,
  output logic               cpu_ready,
  output logic               cpu_int_b,
  output logic               tube_cs_b,
  input  logic [7:0]         tube_dout,
  output logic               iram_cs_b,
  input  logic [15:0]        iram_dout,
  output logic               ram_cs_b,
  output logic               ram_oe_b,
  output logic               ram_we_b,
  output logic [XRAM_AW-1:0] ram_addr,
  output logic [7:0]         ram_data_o,
  output logic               ram_data_oe,
  input  logic [7:0]         ram_data_i,
  input  logic [NIRQ-1:0]    irq_b_in
);

  localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  // state | meaning
  // IDLE  | no external access in flight
  // LO    | byte 0 phase, counting wait states
  // HI    | byte 1 phase, counting wait states
  // DONE  | external access completes, cpu_ready high
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        lo;
  logic [7:0]        hi;
  logic [NIRQ-1:0]   irq_s1;
  logic [NIRQ-1:0]   irq_s2;

  logic tube_hit;
  logic iram_hit;
  logic ext_sel;

  assign tube_hit  = (cpu_addr[ADDR_W-1:3] == TUBE_BASE);
  assign iram_hit  = ((cpu_addr >> IRAM_AW) == '0);
  assign ext_sel   = !tube_hit && !iram_hit;
  assign tube_cs_b = !(cpu_vpa && tube_hit);
  assign iram_cs_b = !(cpu_vpa && !tube_hit && iram_hit);
  assign cpu_ready = !(cpu_vpa && ext_sel) || (state == DONE);

  always_comb begin
    cpu_din = 16'hAAAA;
    if (cpu_vpa) begin
      if (tube_hit)      cpu_din = {8'h00, tube_dout};
      else if (iram_hit) cpu_din = iram_dout;
      else               cpu_din = {hi, lo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rnw_q       <= 1'b1;
      addr_q      <= '0;
      lo          <= 8'h00;
      hi          <= 8'h00;
      ram_cs_b    <= 1'b1;
      ram_oe_b    <= 1'b1;
      ram_we_b    <= 1'b1;
      ram_data_oe <= 1'b0;
      ram_addr    <= '0;
      ram_data_o  <= 8'h00;
    end else begin
      case (state)
        IDLE: if (cpu_vpa && ext_sel) begin
          state       <= LO;
          cnt         <= CNT_W'(WAIT_STATES);
          rnw_q       <= cpu_rnw;
          addr_q      <= cpu_addr;
          ram_cs_b    <= 1'b0;
          ram_oe_b    <= !cpu_rnw;
          ram_we_b    <= cpu_rnw;
          ram_data_oe <= !cpu_rnw;
          ram_addr    <= XRAM_AW'({cpu_addr, 1'b0});
          ram_data_o  <= cpu_dout[7:0];
        end
        LO: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) ram_we_b <= 1'b1;
        end else begin
          if (rnw_q) lo <= ram_data_i;
          state      <= HI;
          cnt        <= CNT_W'(WAIT_STATES);
          ram_we_b   <= rnw_q;
          ram_addr   <= XRAM_AW'({addr_q, 1'b1});
          ram_data_o <= cpu_dout[15:8];
        end
        HI: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) ram_we_b <= 1'b1;
        end else begin
          if (rnw_q) hi <= ram_data_i;
          state       <= DONE;
          ram_cs_b    <= 1'b1;
          ram_oe_b    <= 1'b1;
          ram_we_b    <= 1'b1;
          ram_data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-flop synchroniser per source, then a registered AND-merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_s1    <= '1;
      irq_s2    <= '1;
      cpu_int_b <= 1'b1;
    end else begin
      irq_s1    <= irq_b_in;
      irq_s2    <= irq_s1;
      cpu_int_b <= &irq_s2;
    end
  end

endmodule

// File: tb/tb_copro_bus_ctrl.sv
// Directed bench for copro_bus_ctrl: one instance at WAIT_STATES=1, one at 2.
module tb_copro_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic        cpu_rnw;
  logic        cpu_vpa;
  logic [7:0]  tube_dout;
  logic [15:0] iram_dout;
  logic [7:0]  ram_data_i;
  logic [1:0]  irq_b_in;

  logic [15:0] din1, din2;
  logic        rdy1, rdy2, int1, int2, tcs1, tcs2, ics1, ics2;
  logic        cs1, cs2, oe1, oe2, we1, we2, doe1, doe2;
  logic [18:0] addr1, addr2;
  logic [7:0]  do1, do2;

  int checks = 0;
  int errors = 0;

  always #5 clk = !clk;

  copro_bus_ctrl #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .cpu_vpa(cpu_vpa), .cpu_din(din1), .cpu_ready(rdy1),
    .cpu_int_b(int1), .tube_cs_b(tcs1), .tube_dout(tube_dout), .iram_cs_b(ics1),
    .iram_dout(iram_dout), .ram_cs_b(cs1), .ram_oe_b(oe1), .ram_we_b(we1),
    .ram_addr(addr1), .ram_data_o(do1), .ram_data_oe(doe1),
    .ram_data_i(ram_data_i), .irq_b_in(irq_b_in));

  copro_bus_ctrl #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .cpu_vpa(cpu_vpa), .cpu_din(din2), .cpu_ready(rdy2),
    .cpu_int_b(int2), .tube_cs_b(tcs2), .tube_dout(tube_dout), .iram_cs_b(ics2),
    .iram_dout(iram_dout), .ram_cs_b(cs2), .ram_oe_b(oe2), .ram_we_b(we2),
    .ram_addr(addr2), .ram_data_o(do2), .ram_data_oe(doe2),
    .ram_data_i(ram_data_i), .irq_b_in(irq_b_in));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_we;
    logic [18:0] exp_addr;
    logic [7:0]  exp_do;

    reset = 1'b1; cpu_addr = 16'h0000; cpu_dout = 16'h0000; cpu_rnw = 1'b1;
    cpu_vpa = 1'b0; tube_dout = 8'h00; iram_dout = 16'h0000;
    ram_data_i = 8'h00; irq_b_in = 2'b11;
    tick(); tick();
    check("rst_int_b", int1, 1);
    check("rst_ram_cs_b", cs1, 1);
    check("rst_ram_oe_b", oe1, 1);
    check("rst_ram_we_b", we1, 1);
    check("rst_data_oe", doe1, 0);
    check("rst_ram_addr", addr1, 0);
    check("rst_ram_data_o", do1, 0);
    check("idle_din", din1, 16'hAAAA);
    check("idle_ready", rdy1, 1);
    reset = 1'b0;
    tick();

    // IRAM read
    cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h0100; iram_dout = 16'h1234;
    #1;
    check("iram_cs_b", ics1, 0);
    check("iram_tube_cs_b", tcs1, 1);
    check("iram_ready", rdy1, 1);
    check("iram_din", din1, 16'h1234);
    tick();
    check("iram_sram_idle", cs1, 1);

    // Tube read
    cpu_addr = 16'hFEFA; tube_dout = 8'h5A;
    #1;
    check("tube_cs_b", tcs1, 0);
    check("tube_iram_cs_b", ics1, 1);
    check("tube_din", din1, 16'h005A);
    check("tube_ready", rdy1, 1);
    tick();
    cpu_vpa = 1'b0;
    tick();

    // External read, WAIT_STATES=1: 6-cycle latency
    cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h4000;
    for (int c = 1; c <= 6; c++) begin
      ram_data_i = (c <= 3) ? 8'hCD : 8'hAB;
      #1;
      check($sformatf("xrd_ready_c%0d", c), rdy1, (c == 6));
      if (c >= 2 && c <= 5) begin
        check($sformatf("xrd_cs_b_c%0d", c), cs1, 0);
        check($sformatf("xrd_oe_b_c%0d", c), oe1, 0);
        check($sformatf("xrd_we_b_c%0d", c), we1, 1);
        check($sformatf("xrd_data_oe_c%0d", c), doe1, 0);
        check($sformatf("xrd_addr_c%0d", c), addr1, (c <= 3) ? 19'h08000 : 19'h08001);
      end else begin
        check($sformatf("xrd_cs_b_c%0d", c), cs1, 1);
      end
      if (c == 6) check("xrd_din", din1, 16'hABCD);
      tick();
    end
    cpu_vpa = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // External write on the WAIT_STATES=2 instance: 8-cycle latency
    cpu_vpa = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h2001; cpu_dout = 16'hBEEF;
    for (int c = 1; c <= 8; c++) begin
      #1;
      check($sformatf("xwr_ready_c%0d", c), rdy2, (c == 8));
      if (c >= 2 && c <= 7) begin
        exp_we   = (c == 4 || c == 7);
        exp_addr = (c <= 4) ? 19'h04002 : 19'h04003;
        exp_do   = (c <= 4) ? 8'hEF : 8'hBE;
        check($sformatf("xwr_cs_b_c%0d", c), cs2, 0);
        check($sformatf("xwr_oe_b_c%0d", c), oe2, 1);
        check($sformatf("xwr_data_oe_c%0d", c), doe2, 1);
        check($sformatf("xwr_we_b_c%0d", c), we2, exp_we);
        check($sformatf("xwr_addr_c%0d", c), addr2, exp_addr);
        check($sformatf("xwr_data_o_c%0d", c), do2, exp_do);
      end else begin
        check($sformatf("xwr_cs_b_c%0d", c), cs2, 1);
        check($sformatf("xwr_we_b_c%0d", c), we2, 1);
      end
      tick();
    end
    cpu_vpa = 1'b0; cpu_rnw = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // Reset during the HI phase, then the held read reruns from IDLE
    cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h4000; ram_data_i = 8'h11;
    tick(); tick(); tick();
    check("rmid_in_hi_addr", addr1, 19'h08001);
    check("rmid_in_hi_cs_b", cs1, 0);
    reset = 1'b1;
    tick();
    check("rmid_cs_b", cs1, 1);
    check("rmid_oe_b", oe1, 1);
    check("rmid_data_oe", doe1, 0);
    check("rmid_ready", rdy1, 0);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      ram_data_i = (c <= 3) ? 8'h34 : 8'h12;
      #1;
      check($sformatf("rerun_ready_c%0d", c), rdy1, (c == 6));
      check($sformatf("rerun_cs_b_c%0d", c), cs1, (c == 1 || c == 6));
      if (c == 6) check("rerun_din", din1, 16'h1234);
      tick();
    end
    cpu_vpa = 1'b0;
    tick();

    // Single-cycle pulse on irq 1
    irq_b_in = 2'b01;
    tick();
    irq_b_in = 2'b11;
    check("irq1_e1", int1, 1);
    tick(); check("irq1_e2", int1, 1);
    tick(); check("irq1_e3", int1, 0);
    tick(); check("irq1_e4", int1, 1);
    tick(); check("irq1_e5", int1, 1);

    // Both sources low for 4 cycles
    irq_b_in = 2'b00;
    tick(); check("irq01_e1", int1, 1);
    tick(); check("irq01_e2", int1, 1);
    tick(); check("irq01_e3", int1, 0);
    tick(); check("irq01_e4", int1, 0);
    irq_b_in = 2'b10;
    tick(); check("irq01_r1", int1, 0);
    irq_b_in = 2'b11;
    tick(); check("irq01_r2", int1, 0);
    tick(); check("irq01_r3", int1, 0);
    tick(); check("irq01_r4", int1, 1);
    check("irq_dut2", int2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
